w0rm_core_writeback: RTL and testbench

Writeback stage of the W0RM core pipeline. It sits directly downstream of the memory stage and consumes its completed results: ALU results or load data. It extends load data to register width, buffers up to two results in a skid buffer, and issues register-file writes under a ready/valid handshake. A stack pop produces a second write that increments the stack pointer.

---
 rtl/w0rm_core_pkg.sv | 17 +
 rtl/w0rm_core_writeback_if.sv | 45 ++++
 rtl/w0rm_load_extend.sv | 23 ++
 rtl/w0rm_core_writeback.sv | 118 +++++++++++
 tb/tb_w0rm_core_writeback.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/w0rm_core_pkg.sv
// w0rm_core_pkg: shared load-size, data-source and writeback FSM encodings for the W0RM core.
package w0rm_core_pkg;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_DATA = 2'd1,
        WB_SP   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/w0rm_core_writeback_if.sv
// w0rm_core_writeback_if: memory-stage entry handshake plus register-file write/forward bus of the writeback stage.
interface w0rm_core_writeback_if #(
    parameter int USER_WIDTH     = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                      wb_valid_in;
    logic                      wb_ready_out;
    logic [DATA_WIDTH-1:0]     wb_result_in;
    logic [DATA_WIDTH-1:0]     wb_mem_data_in;
    logic                      wb_data_src;
    logic [1:0]                wb_load_size;
    logic                      wb_load_signed;
    logic [1:0]                wb_byte_offset;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_dest_reg;
    logic                      wb_is_pop;
    logic [DATA_WIDTH-1:0]     wb_sp_in;
    logic [USER_WIDTH-1:0]     user_data_in;
    logic                      rf_write_en;
    logic [REG_ADDR_WIDTH-1:0] rf_write_addr;
    logic [DATA_WIDTH-1:0]     rf_write_data;
    logic                      rf_write_ready;
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_addr;
    logic [DATA_WIDTH-1:0]     fwd_data;
    logic [USER_WIDTH-1:0]     user_data_out;

    modport master (
        output wb_valid_in, wb_result_in, wb_mem_data_in, wb_data_src, wb_load_size,
               wb_load_signed, wb_byte_offset, wb_reg_write, wb_dest_reg, wb_is_pop,
               wb_sp_in, user_data_in, rf_write_ready,
        input  wb_ready_out, rf_write_en, rf_write_addr, rf_write_data,
               fwd_valid, fwd_addr, fwd_data, user_data_out
    );

    modport slave (
        input  wb_valid_in, wb_result_in, wb_mem_data_in, wb_data_src, wb_load_size,
               wb_load_signed, wb_byte_offset, wb_reg_write, wb_dest_reg, wb_is_pop,
               wb_sp_in, user_data_in, rf_write_ready,
        output wb_ready_out, rf_write_en, rf_write_addr, rf_write_data,
               fwd_valid, fwd_addr, fwd_data, user_data_out
    );

endinterface

// File: rtl/w0rm_load_extend.sv
// w0rm_load_extend: selects the addressed byte/half/word of a load and zero- or sign-extends it.
module w0rm_load_extend
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{offset, 3'b000} +: 8];
        h    = word[{offset[1], 4'b0000} +: 16];
        data = size == LOAD_BYTE ? {{(DATA_WIDTH-8){sign_ext & b[7]}}, b} :
               size == LOAD_HALF ? {{(DATA_WIDTH-16){sign_ext & h[15]}}, h} : word;
    end

endmodule

// File: rtl/w0rm_core_writeback.sv
// w0rm_core_writeback: 2-entry skid buffer feeding register-file writes, with a second SP write for stack pops.
module w0rm_core_writeback
    import w0rm_core_pkg::*;
#(
    parameter int USER_WIDTH     = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int SP_INDEX       = 14,
    parameter int STACK_STEP     = 4
) (
    input logic clk,
    input logic reset,
    w0rm_core_writeback_if.slave wb
);
    localparam logic [REG_ADDR_WIDTH-1:0] SP_ADDR = REG_ADDR_WIDTH'(SP_INDEX);

    logic [DATA_WIDTH-1:0]     q_data [2];
    logic [DATA_WIDTH-1:0]     q_sp   [2];
    logic [REG_ADDR_WIDTH-1:0] q_dest [2];
    logic                      q_rw   [2];
    logic                      q_pop  [2];
    logic [USER_WIDTH-1:0]     q_user [2];

    wb_state_t                 state;
    logic [1:0]                count, count_next;
    logic                      rd_ptr, wr_ptr, ready_q;
    logic                      rf_en;
    logic [REG_ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0]     rf_data;

    logic [DATA_WIDTH-1:0]     ext_data, in_data, in_sp;
    logic                      push, split_pop, to_sp, retire, hold, stored, load, nxt;
    logic                      nxt_rw;
    logic [REG_ADDR_WIDTH-1:0] nxt_dest;
    logic [DATA_WIDTH-1:0]     nxt_data;

    w0rm_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .word     (wb.wb_mem_data_in),
        .size     (wb.wb_load_size),
        .sign_ext (wb.wb_load_signed),
        .offset   (wb.wb_byte_offset),
        .data     (ext_data)
    );

    // The next head comes from the buffer if an older entry survives this edge, else straight from the input.
    always_comb begin
        in_data    = wb.wb_data_src == WB_SRC_MEM ? ext_data : wb.wb_result_in;
        in_sp      = wb.wb_sp_in + DATA_WIDTH'(STACK_STEP);
        push       = wb.wb_valid_in && ready_q;
        split_pop  = q_pop[rd_ptr] && q_dest[rd_ptr] != SP_ADDR;
        to_sp      = state == WB_DATA && (q_rw[rd_ptr] ? wb.rf_write_ready && split_pop : q_pop[rd_ptr]);
        retire     = state == WB_SP ? wb.rf_write_ready :
                     state == WB_DATA && (q_rw[rd_ptr] ? wb.rf_write_ready && !split_pop : !q_pop[rd_ptr]);
        hold       = state != WB_IDLE && !to_sp && !retire;
        stored     = count > {1'b0, retire};
        nxt        = rd_ptr ^ retire;
        nxt_rw     = stored ? q_rw[nxt]   : wb.wb_reg_write;
        nxt_dest   = stored ? q_dest[nxt] : wb.wb_dest_reg;
        nxt_data   = stored ? q_data[nxt] : in_data;
        load       = !hold && !to_sp && (stored || push);
        count_next = count + {1'b0, push} - {1'b0, retire};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= in_data;
            q_sp[wr_ptr]   <= in_sp;
            q_dest[wr_ptr] <= wb.wb_dest_reg;
            q_rw[wr_ptr]   <= wb.wb_reg_write;
            q_pop[wr_ptr]  <= wb.wb_is_pop;
            q_user[wr_ptr] <= wb.user_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WB_IDLE;
            count   <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            ready_q <= 1'b1;
            rf_en   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            count   <= count_next;
            ready_q <= count_next < 2'd2;
            wr_ptr  <= wr_ptr ^ push;
            rd_ptr  <= nxt;
            if (to_sp) begin
                state   <= WB_SP;
                rf_en   <= 1'b1;
                rf_addr <= SP_ADDR;
                rf_data <= q_sp[rd_ptr];
            end else if (load) begin
                state   <= WB_DATA;
                rf_en   <= nxt_rw;
                rf_addr <= nxt_dest;
                rf_data <= nxt_data;
            end else if (!hold) begin
                state   <= WB_IDLE;
                rf_en   <= 1'b0;
                rf_addr <= '0;
                rf_data <= '0;
            end
        end
    end

    assign wb.wb_ready_out  = ready_q;
    assign wb.rf_write_en   = rf_en;
    assign wb.rf_write_addr = rf_addr;
    assign wb.rf_write_data = rf_data;
    assign wb.fwd_valid     = rf_en;
    assign wb.fwd_addr      = rf_addr;
    assign wb.fwd_data      = rf_data;
    assign wb.user_data_out = state == WB_IDLE ? '0 : q_user[rd_ptr];

endmodule

// File: tb/tb_w0rm_core_writeback.sv
// tb_w0rm_core_writeback: directed stimulus with an expected-write queue checked as writes leave the stage.
module tb_w0rm_core_writeback;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    w0rm_core_writeback_if #(.USER_WIDTH(1), .DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus ();

    w0rm_core_writeback dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (bus.fwd_valid === bus.rf_write_en && bus.fwd_addr === bus.rf_write_addr && bus.fwd_data === bus.rf_write_data)
            else begin
                errors++;
                $error("FAIL fwd_mirror: fwd %0b/%0d/%h rf %0b/%0d/%h", bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                       bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
            end
            if (bus.rf_write_en === 1'b1 && bus.rf_write_ready === 1'b1) begin
                checks++;
                assert (exp_q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_write: got r%0d=%h, expected no write", bus.rf_write_addr, bus.rf_write_data);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    assert ({bus.rf_write_addr, bus.rf_write_data} === {mon_e.a, mon_e.d})
                    else begin
                        errors++;
                        $error("FAIL write_order: got r%0d=%h, expected r%0d=%h", bus.rf_write_addr, bus.rf_write_data, mon_e.a, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic present(input logic src, input logic [1:0] size, input logic sgn, input logic [1:0] off,
                           input logic rw, input logic [3:0] dest, input logic pop,
                           input logic [31:0] res, input logic [31:0] mem, input logic [31:0] sp, input logic usr);
        bus.wb_data_src    = src;
        bus.wb_load_size   = size;
        bus.wb_load_signed = sgn;
        bus.wb_byte_offset = off;
        bus.wb_reg_write   = rw;
        bus.wb_dest_reg    = dest;
        bus.wb_is_pop      = pop;
        bus.wb_result_in   = res;
        bus.wb_mem_data_in = mem;
        bus.wb_sp_in       = sp;
        bus.user_data_in   = usr;
        bus.wb_valid_in    = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        logic acc;
        do begin
            @(negedge clk);
            acc = bus.wb_ready_out;
            @(posedge clk);
            #1;
            n++;
        end while (acc !== 1'b1 && n < 50);
        bus.wb_valid_in = 1'b0;
        checks++;
        assert (acc === 1'b1)
        else begin
            errors++;
            $error("FAIL accept_%s: wb_ready_out=%b, expected 1 within 50 cycles", tag, acc);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain_%s: %0d writes outstanding, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.rf_write_ready = 1'b0;
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.wb_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_en", 64'(bus.rf_write_en), 64'd0);
        check("reset_addr_data", {28'd0, bus.rf_write_addr, bus.rf_write_data}, 64'd0);
        check("reset_ready", 64'(bus.wb_ready_out), 64'd1);
        check("reset_fwd_user", {62'd0, bus.fwd_valid, bus.user_data_out}, 64'd0);
        reset = 1'b0;
        bus.rf_write_ready = 1'b1;

        // word load, one-cycle latency
        expect_wr(4'd3, 32'hDEADBEEF);
        present(1'b1, 2'b10, 1'b0, 2'b01, 1'b1, 4'd3, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1);
        wait_accept("word");
        @(negedge clk);
        check("latency_word", {31'd0, bus.rf_write_en, 28'd0, bus.rf_write_addr}, {31'd0, 1'b1, 28'd0, 4'd3});
        check("user_out", 64'(bus.user_data_out), 64'd1);
        drain("word");

        // back-to-back: sub-word loads and an ALU result
        expect_wr(4'd5, 32'hFFFFFF80);
        present(1'b1, 2'b00, 1'b1, 2'b10, 1'b1, 4'd5, 1'b0, 32'h0, 32'h00800000, 32'h0, 1'b0);
        wait_accept("sbyte");
        expect_wr(4'd6, 32'h00008001);
        present(1'b1, 2'b01, 1'b0, 2'b11, 1'b1, 4'd6, 1'b0, 32'h0, 32'h80010000, 32'h0, 1'b0);
        wait_accept("uhalf");
        expect_wr(4'd7, 32'h12345678);
        present(1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 4'd7, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h0, 1'b0);
        wait_accept("alu");
        expect_wr(4'd8, 32'hFFFF8001);
        present(1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 4'd8, 1'b0, 32'h0, 32'h12348001, 32'h0, 1'b0);
        wait_accept("shalf");
        expect_wr(4'd9, 32'h000000AB);
        present(1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 4'd9, 1'b0, 32'h0, 32'hAB000000, 32'h0, 1'b0);
        wait_accept("ubyte");
        drain("subword");

        // pop: data write then SP write on the following cycle
        expect_wr(4'd2, 32'h00000055);
        expect_wr(4'd14, 32'h00000104);
        present(1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 4'd2, 1'b1, 32'h0, 32'h00000055, 32'h00000100, 1'b0);
        wait_accept("pop");
        @(negedge clk);
        check("pop_first", 64'(bus.rf_write_addr), 64'd2);
        @(negedge clk);
        check("pop_second", {31'd0, bus.rf_write_en, bus.rf_write_data}, {31'd0, 1'b1, 32'h00000104});
        drain("pop");

        // non-writing pop still bumps SP; a non-writing, non-pop entry writes nothing
        expect_wr(4'd14, 32'h00000014);
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 4'd1, 1'b1, 32'h0, 32'h0, 32'h00000010, 1'b0);
        wait_accept("nowrite_pop");
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 4'd1, 1'b0, 32'hCAFE0000, 32'h0, 32'h0, 1'b0);
        wait_accept("nowrite");
        drain("nowrite");

        // backpressure: two accepted, third held, then consecutive writes in order
        bus.rf_write_ready = 1'b0;
        expect_wr(4'd1, 32'h00000011);
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 4'd1, 1'b0, 32'h00000011, 32'h0, 32'h0, 1'b0);
        wait_accept("bp_a");
        expect_wr(4'd4, 32'h00000022);
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 4'd4, 1'b0, 32'h00000022, 32'h0, 32'h0, 1'b0);
        wait_accept("bp_b");
        expect_wr(4'd9, 32'h00000033);
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 4'd9, 1'b0, 32'h00000033, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full", 64'(bus.wb_ready_out), 64'd0);
            check("bp_hold", {31'd0, bus.rf_write_en, 28'd0, bus.rf_write_addr}, {31'd0, 1'b1, 28'd0, 4'd1});
            check("bp_hold_data", 64'(bus.rf_write_data), 64'h11);
            @(posedge clk);
            #1;
        end
        bus.rf_write_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stream", 64'(bus.rf_write_en), 64'd1);
            if (i == 1) check("bp_ready_rise", 64'(bus.wb_ready_out), 64'd1);
            @(posedge clk);
            #1;
            if (i == 1) bus.wb_valid_in = 1'b0;
        end
        drain("backpressure");

        // pop into the SP itself: a single write
        expect_wr(4'd14, 32'h00000200);
        present(1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 4'd14, 1'b1, 32'h0, 32'h00000200, 32'h00000500, 1'b0);
        wait_accept("pop_sp");
        drain("pop_sp");

        // reset while the SP write is stalled
        expect_wr(4'd2, 32'h00000077);
        present(1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 4'd2, 1'b1, 32'h0, 32'h00000077, 32'h00000300, 1'b1);
        wait_accept("pop_rst");
        @(posedge clk);
        #1;
        bus.rf_write_ready = 1'b0;
        @(negedge clk);
        check("sp_state", {31'd0, bus.rf_write_en, bus.rf_write_data}, {31'd0, 1'b1, 32'h00000304});
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_en", 64'(bus.rf_write_en), 64'd0);
        check("rst_mid_ready", 64'(bus.wb_ready_out), 64'd1);
        check("rst_mid_outs", {27'd0, bus.fwd_valid, bus.user_data_out, bus.rf_write_addr, bus.rf_write_data}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rf_write_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(bus.rf_write_en), 64'd0);
        end
        @(posedge clk);
        #1;
        expect_wr(4'd10, 32'h00000099);
        present(1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 4'd10, 1'b0, 32'h00000099, 32'h0, 32'h0, 1'b0);
        wait_accept("post_rst");
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
